operand_encoder: RTL and testbench
==================================

// Module: operand_encoder
// PURPOSE
//  Front-panel input encoder: the producer end of the 12-bit coded operand word that the complement decoder unpacks.
//  Debounces Btn2 (confirm) and Btn3 (cancel) and steps through operand A, operation and operand B, sampled from Sw.
//  Packs the result into one 12-bit word; the CPU polls and acknowledges it over the memory-mapped data bus.
//  Drives the display-decoder msg code so the user sees which field is expected.
// PARAMETERS
//  DATA_W           32      CPU data bus width
//  DEBOUNCE_CYCLES  500000  stable cycles before a button level is accepted (10 ms @ 50 MHz)
//  CNT_W            19      debounce counter width; must hold DEBOUNCE_CYCLES
//  NUM_OPS          4       legal operation codes are 0..NUM_OPS-1
// PORTS
//  clk         in   1       system clock
//  rst         in   1       asynchronous, active-high reset
//  btn_confirm in   1       raw Btn2 level (async)
//  btn_cancel  in   1       raw Btn3 level (async)
//  sw          in   8       raw switches (async); only sw[3:0] is used
//  sel         in   1       address-decoder select for this block
//  wr_enable   in   1       bus write strobe; sel & wr_enable = acknowledge
//  data_out    out  DATA_W  status/word read by the CPU; 0 when sel=0
//  msg         out  2       to display decoder: 00 normal, 01 OP, 10 VAL, 11 ERR
// BEHAVIOUR
//  - One clock domain; rst is asynchronous, active-high, and clears every flop.
//  - Reset values: state=GET_A, fields=0, err=0, ready=0, msg=2'b10, data_out=0.
//  - Btn/sw pass through a 2-flop synchroniser. A button's debounced level changes only after it has been stable
//    for DEBOUNCE_CYCLES consecutive cycles. Press = 1-cycle pulse on the debounced 0->1 edge.
//  - FSM states: GET_A, GET_OP, GET_B, READY.
//    GET_A : confirm -> first=sw[3:0], go GET_OP.
//    GET_OP: confirm with sw[3:0]<NUM_OPS -> op=sw[3:0], err=0, go GET_B.
//            confirm with an illegal code -> err=1, stay.
//    GET_B : confirm -> second=sw[3:0], go READY, ready=1.
//    READY : ack (sel&wr_enable, any data) -> ready=0, go GET_A; the fields are held.
//  - Cancel steps back one state: GET_OP->GET_A, GET_B->GET_OP, READY->GET_B with ready=0. Cancel in GET_A has no effect.
//    Any state change clears err.
//  - Simultaneous events:
//    confirm+cancel in the same cycle -> cancel wins.
//    ack+cancel in READY -> ack wins.
//    ack outside READY -> ignored.
//  - Coded word: word[3:0]=first, word[7:4]=second, word[11:8]=op. The word is registered and updates on the cycle
//    after confirm.
//  - data_out (combinational, sel=1): [11:0]=word, [12]=ready, [13]=err, [15:14]=state, upper bits 0.
//    Read latency 0 (same cycle as sel).
//  - msg: err=1 -> 11; GET_OP -> 01; GET_A/GET_B -> 10; READY -> 00.
//  - Reset mid-sequence abandons the entry; the word already read is unaffected in the CPU.
// STRUCTURE
//  - Shared header: state encodings, field offsets (FIRST_LSB=0, SECOND_LSB=4, OP_LSB=8, READY_BIT=12, ERR_BIT=13),
//    msg codes (MSG_NORMAL/OP/VAL/ERR).
//  - Sub-module btn_debounce (synchroniser + counter + edge pulse), instantiated twice.
//    sw uses the synchroniser only.
//  - Top: FSM, field registers, read mux.
// TESTING (sim with DEBOUNCE_CYCLES=4)
//  1. sw=3 confirm, sw=1 confirm, sw=9 confirm -> ready=1, data_out[12:0]=0x1193, msg=00.
//  2. In READY, sel=1, wr_enable=1 for 1 cycle -> ready=0, state GET_A, msg=10; a 2nd ack is ignored.
//  3. In GET_OP, sw=7 confirm -> err=1, msg=11, state stays; then sw=2 confirm -> err=0, GET_B.
//  4. Glitch on btn_confirm of 2 cycles -> no state change; hold 6 cycles -> exactly one advance.
//  5. In READY, cancel -> GET_B, ready=0; cancel+confirm together in GET_B -> GET_OP.
//  6. Assert rst asynchronously in GET_B -> all outputs at reset values in the same cycle; sel=0 -> data_out=0.

Source files
------------

// File: rtl/operand_encoder_pkg.sv
// Shared definitions for the operand encoder: FSM encodings, coded-word field offsets and
// display message codes.
package operand_encoder_pkg;

    // Encoding is visible to the CPU in data_out[15:14].
    typedef enum logic [1:0] {
        StGetA  = 2'd0,
        StGetOp = 2'd1,
        StGetB  = 2'd2,
        StReady = 2'd3
    } enc_state_e;

    localparam int unsigned FIELD_W    = 4;
    localparam int unsigned WORD_W     = 12;
    localparam int unsigned FIRST_LSB  = 0;
    localparam int unsigned SECOND_LSB = 4;
    localparam int unsigned OP_LSB     = 8;
    localparam int unsigned READY_BIT  = 12;
    localparam int unsigned ERR_BIT    = 13;
    localparam int unsigned STATE_LSB  = 14;
    localparam int unsigned STATUS_W   = 16;

    localparam logic [1:0] MSG_NORMAL = 2'b00;
    localparam logic [1:0] MSG_OP     = 2'b01;
    localparam logic [1:0] MSG_VAL    = 2'b10;
    localparam logic [1:0] MSG_ERR    = 2'b11;

    // Error display overrides the field prompt.
    function automatic logic [1:0] msg_for(enc_state_e st, logic err);
        logic [1:0] m;
        if (err) begin
            m = MSG_ERR;
        end else begin
            unique case (st)
                StGetOp: m = MSG_OP;
                StReady: m = MSG_NORMAL;
                default: m = MSG_VAL;
            endcase
        end
        return m;
    endfunction

endpackage

// File: rtl/operand_encoder_debounce.sv
// btn_debounce: two-flop synchroniser, stability counter and rising-edge press pulse for one
// raw push-button.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    logic             sync1_q, sync2_q;
    logic             level_q, level_d;
    logic             press_q, press_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Bring the asynchronous button level into the clock domain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
        end
    end

    // Accept a new level only after it has differed from the current one for the full window.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level_d = sync2_q;
                press_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/operand_encoder.sv
// operand_encoder: collects operand A, operation and operand B from the switches, packs them into
// a 12-bit coded word and presents it to the CPU for polling and acknowledgement.
module operand_encoder
    import operand_encoder_pkg::*;
#(
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19,
    parameter int unsigned NUM_OPS         = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_confirm,
    input  logic              btn_cancel,
    input  logic [7:0]        sw,
    input  logic              sel,
    input  logic              wr_enable,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        msg
);

    logic confirm, cancel, ack;
    logic [FIELD_W-1:0] sw_s1_q, sw_s2_q;
    logic unused_sw;

    enc_state_e state_q, state_d;
    logic err_q, err_d;
    logic ready_q, ready_d;
    logic [FIELD_W-1:0] first_q, first_d;
    logic [FIELD_W-1:0] op_q, op_d;
    logic [FIELD_W-1:0] second_q, second_d;
    logic [WORD_W-1:0] word;
    logic op_legal;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_db_confirm (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_confirm),
        .press(confirm)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_db_cancel (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_cancel),
        .press(cancel)
    );

    assign unused_sw = ^sw[7:4];
    assign ack       = sel & wr_enable;
    assign op_legal  = 32'(sw_s2_q) < NUM_OPS;

    // Switches only need synchronising; they are sampled on a debounced confirm.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            sw_s1_q <= sw[FIELD_W-1:0];
            sw_s2_q <= sw_s1_q;
        end
    end

    // Entry sequencing; cancel beats confirm, ack beats cancel in READY.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        first_d  = first_q;
        op_d     = op_q;
        second_d = second_q;
        unique case (state_q)
            StGetA: begin
                if (confirm && !cancel) begin
                    first_d = sw_s2_q;
                    state_d = StGetOp;
                end
            end
            StGetOp: begin
                if (cancel) begin
                    state_d = StGetA;
                end else if (confirm) begin
                    if (op_legal) begin
                        op_d    = sw_s2_q;
                        state_d = StGetB;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            StGetB: begin
                if (cancel) begin
                    state_d = StGetOp;
                end else if (confirm) begin
                    second_d = sw_s2_q;
                    state_d  = StReady;
                end
            end
            StReady: begin
                if (ack) begin
                    state_d = StGetA;
                end else if (cancel) begin
                    state_d = StGetB;
                end
            end
            default: state_d = StGetA;
        endcase
        if (state_d != state_q) begin
            err_d = 1'b0;
        end
        ready_d = (state_d == StReady);
    end

    // FSM and field registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StGetA;
            err_q    <= 1'b0;
            ready_q  <= 1'b0;
            first_q  <= '0;
            op_q     <= '0;
            second_q <= '0;
        end else begin
            state_q  <= state_d;
            err_q    <= err_d;
            ready_q  <= ready_d;
            first_q  <= first_d;
            op_q     <= op_d;
            second_q <= second_d;
        end
    end

    always_comb begin
        word = '0;
        word[FIRST_LSB +: FIELD_W]  = first_q;
        word[SECOND_LSB +: FIELD_W] = second_q;
        word[OP_LSB +: FIELD_W]     = op_q;
    end

    // Zero-latency read mux; bus sees zeros when not selected.
    always_comb begin
        data_out = '0;
        if (sel) begin
            data_out[WORD_W-1:0]     = word;
            data_out[READY_BIT]      = ready_q;
            data_out[ERR_BIT]        = err_q;
            data_out[STATE_LSB +: 2] = state_q;
        end
    end

    // Display prompt for the field the user is expected to enter.
    always_comb begin
        msg = msg_for(state_q, err_q);
    end

endmodule

// File: tb/tb_operand_encoder.sv
// Self-checking bench for operand_encoder: directed scenarios plus randomized button/switch
// activity compared against an abstract model of the entry sequence.
module tb_operand_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_confirm, btn_cancel;
    logic [7:0]  sw;
    logic        sel, wr_enable;
    logic [31:0] data_out;
    logic [1:0]  msg;

    int n_tests = 0;
    int n_fail  = 0;

    // Model: state 0=GET_A 1=GET_OP 2=GET_B 3=READY
    int m_state, m_err, m_first, m_op, m_second;

    operand_encoder #(
        .DATA_W         (32),
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (3),
        .NUM_OPS        (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_confirm(btn_confirm),
        .btn_cancel (btn_cancel),
        .sw         (sw),
        .sel        (sel),
        .wr_enable  (wr_enable),
        .data_out   (data_out),
        .msg        (msg)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_data();
        int ready = (m_state == 3) ? 1 : 0;
        return 32'((m_state << 14) + (m_err << 13) + (ready << 12) + (m_op << 8)
                   + (m_second << 4) + m_first);
    endfunction

    function automatic logic [31:0] exp_msg();
        if (m_err != 0) return 32'd3;
        if (m_state == 1) return 32'd1;
        if (m_state == 3) return 32'd0;
        return 32'd2;
    endfunction

    task automatic model_reset();
        m_state = 0; m_err = 0; m_first = 0; m_op = 0; m_second = 0;
    endtask

    task automatic model_confirm(input int v);
        case (m_state)
            0: begin m_first = v; m_state = 1; end
            1: begin
                if (v < 4) begin m_op = v; m_state = 2; m_err = 0; end
                else m_err = 1;
            end
            2: begin m_second = v; m_state = 3; end
            default: ;
        endcase
    endtask

    task automatic model_cancel();
        if (m_state != 0) begin m_state = m_state - 1; m_err = 0; end
    endtask

    task automatic model_ack();
        if (m_state == 3) m_state = 0;
    endtask

    task automatic check_out(input string tag);
        @(negedge clk);
        check({tag, ".data"}, data_out, exp_data());
        check({tag, ".msg"}, {30'd0, msg}, exp_msg());
        @(posedge clk); #1;
    endtask

    // Hold the chosen buttons for a number of cycles, then release and let the release settle.
    task automatic hold_btns(input bit c, input bit x, input int cycles);
        btn_confirm = c;
        btn_cancel  = x;
        repeat (cycles) @(posedge clk);
        #1;
        btn_confirm = 1'b0;
        btn_cancel  = 1'b0;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic do_confirm(input logic [7:0] v);
        sw = v;
        hold_btns(1'b1, 1'b0, 10);
        model_confirm(int'(v[3:0]));
    endtask

    task automatic do_cancel();
        hold_btns(1'b0, 1'b1, 10);
        model_cancel();
    endtask

    task automatic do_ack();
        wr_enable = 1'b1;
        @(posedge clk); #1;
        wr_enable = 1'b0;
        repeat (2) @(posedge clk); #1;
        model_ack();
    endtask

    initial begin
        rst = 1'b1; btn_confirm = 0; btn_cancel = 0; sw = 0; sel = 1; wr_enable = 0;
        model_reset();
        repeat (3) @(posedge clk); #1;
        check_out("reset");
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // 1: full entry
        do_confirm(8'h03); check_out("t1.a");
        do_confirm(8'h01); check_out("t1.op");
        do_confirm(8'h09); check_out("t1.ready");
        check("t1.word", data_out & 32'h1fff, 32'h1193);
        check("t1.msg0", {30'd0, msg}, 32'd0);

        // 2: ack then a second, ignored ack
        do_ack(); check_out("t2.ack");
        do_ack(); check_out("t2.ack2");

        // 3: illegal op then legal op
        do_confirm(8'h05); check_out("t3.a");
        do_confirm(8'h07); check_out("t3.illegal");
        check("t3.msg_err", {30'd0, msg}, 32'd3);
        do_confirm(8'h02); check_out("t3.legal");

        // 4: short glitch must not register; a 6-cycle hold advances exactly once
        sw = 8'h0c;
        hold_btns(1'b1, 1'b0, 2); check_out("t4.glitch");
        hold_btns(1'b1, 1'b0, 6); model_confirm(12); check_out("t4.hold");

        // 5: cancel from READY, then cancel+confirm together in GET_B
        do_cancel(); check_out("t5.cancel");
        sw = 8'h0f;
        hold_btns(1'b1, 1'b1, 10); model_cancel(); check_out("t5.both");

        // ack coinciding with the cancel press in READY: ack wins.
        // Press pulse arrives 2 sync cycles + 4 stable cycles after the raw edge.
        do_confirm(8'h01); do_confirm(8'h06); check_out("t5.ready");
        btn_cancel = 1'b1;
        repeat (6) @(posedge clk); #1;
        wr_enable = 1'b1;
        @(posedge clk); #1;
        wr_enable = 1'b0;
        repeat (3) @(posedge clk); #1;
        btn_cancel = 1'b0;
        repeat (12) @(posedge clk); #1;
        model_ack();
        check_out("t5.ack_cancel");

        // 6: asynchronous reset in GET_B
        do_confirm(8'h0a); do_confirm(8'h03); check_out("t6.getb");
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("t6.rst_data", data_out, exp_data());
        check("t6.rst_msg", {30'd0, msg}, 32'd2);
        sel = 1'b0;
        #1;
        check("t6.sel0", data_out, 32'd0);
        sel = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (2) @(posedge clk); #1;
        check_out("t6.after");

        // Randomized sequence
        for (int i = 0; i < 80; i++) begin
            int act = int'($urandom_range(0, 4));
            case (act)
                0, 1: do_confirm(8'($urandom));
                2: do_cancel();
                3: begin
                    sw = 8'($urandom);
                    hold_btns(1'b1, 1'b1, 10);
                    model_cancel();
                end
                default: do_ack();
            endcase
            check_out("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always terminates.
    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish before limit");
        $fatal(1, "timeout");
    end

endmodule
